// File: rtl/mod_ctrl_pkg.sv
// Shared definitions for the programmable mod-N counter controller and its core.
package mod_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } ctrlState_t;

   localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/mod_n_core.sv
// WIDTH-bit up/down mod-N counter; latches modulus and direction on load and
// flags the last value before a reload so the controller can register Wrap.
module mod_n_core #(
   parameter int WIDTH = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clear,
   input  logic             load,
   input  logic             enable,
   input  logic             down,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] count,
   output logic             atEnd
);

   logic [WIDTH-1:0] modLatch;
   logic             downLatch;
   logic [WIDTH-1:0] topValue;

   assign topValue = modLatch - 1'b1;
   assign atEnd    = downLatch ? (count == '0) : (count == topValue);

   // Clear wins over load, load over enable; the reload value depends on direction.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count     <= '0;
         modLatch  <= '0;
         downLatch <= 1'b0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         modLatch  <= modulus;
         downLatch <= down;
         count     <= down ? (modulus - 1'b1) : '0;
      end else if (enable) begin
         if (atEnd)
            count <= downLatch ? topValue : '0;
         else
            count <= downLatch ? (count - 1'b1) : (count + 1'b1);
      end
   end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run controller for the mod-N core: start/stop/hold sequencing, pass counting,
// and the registered Wrap/Done/Error pulses.
module mod_counter_ctrl
   import mod_ctrl_pkg::*;
#(
   parameter int WIDTH  = 3,
   parameter int PASS_W = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stop,
   input  logic              Hold,
   input  logic              Down,
   input  logic [WIDTH-1:0]  Modulus,
   input  logic [PASS_W-1:0] Passes,
   output logic [WIDTH-1:0]  Count,
   output logic              Wrap,
   output logic              Busy,
   output logic              Done,
   output logic              Error
);

   ctrlState_t        state, nextState;
   logic [PASS_W-1:0] passCnt, passesLat, passNext;
   logic              coreClear, coreLoad, coreEnable, atEnd;
   logic              wrapNext, doneNext, errorNext, passClear, passInc;

   mod_n_core #(.WIDTH(WIDTH)) core (
      .Clock   (Clock),
      .Reset   (Reset),
      .clear   (coreClear),
      .load    (coreLoad),
      .enable  (coreEnable),
      .down    (Down),
      .modulus (Modulus),
      .count   (Count),
      .atEnd   (atEnd)
   );

   assign passNext = passCnt + 1'b1;
   assign Busy     = (state != IDLE);

   // State, pass bookkeeping and the one-cycle pulse registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         passCnt   <= '0;
         passesLat <= '0;
         Wrap      <= 1'b0;
         Done      <= 1'b0;
         Error     <= 1'b0;
      end else begin
         state <= nextState;
         Wrap  <= wrapNext;
         Done  <= doneNext;
         Error <= errorNext;
         if (passClear) begin
            passCnt   <= '0;
            passesLat <= Passes;
         end else if (passInc) begin
            passCnt <= passNext;
         end
      end
   end

   // Stop outranks everything; a zero pass count means the run never ends by itself.
   always_comb begin
      nextState  = state;
      coreClear  = 1'b0;
      coreLoad   = 1'b0;
      coreEnable = 1'b0;
      wrapNext   = 1'b0;
      doneNext   = 1'b0;
      errorNext  = 1'b0;
      passClear  = 1'b0;
      passInc    = 1'b0;
      case (state)
         IDLE: begin
            if (!Stop && Start) begin
               if (Modulus >= WIDTH'(MIN_MODULUS)) begin
                  coreLoad  = 1'b1;
                  passClear = 1'b1;
                  nextState = RUN;
               end else begin
                  errorNext = 1'b1;
               end
            end
         end
         RUN: begin
            if (Stop) begin
               coreClear = 1'b1;
               nextState = IDLE;
            end else if (Hold) begin
               nextState = PAUSE;
            end else begin
               coreEnable = 1'b1;
               if (atEnd) begin
                  wrapNext = 1'b1;
                  if (passesLat != '0) begin
                     passInc = 1'b1;
                     if (passNext == passesLat) begin
                        doneNext  = 1'b1;
                        nextState = IDLE;
                     end
                  end
               end
            end
         end
         PAUSE: begin
            if (Stop) begin
               coreClear = 1'b1;
               nextState = IDLE;
            end else if (!Hold) begin
               nextState = RUN;
            end
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Directed bench for mod_counter_ctrl: behavioural run model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_mod_counter_ctrl;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Stop  = 1'b0;
   logic       Hold  = 1'b0;
   logic       Down  = 1'b0;
   logic [2:0] Modulus = 3'd0;
   logic [3:0] Passes  = 4'd0;
   logic [2:0] Count;
   logic       Wrap, Busy, Done, Error;

   int vectors    = 0;
   int miscompares = 0;

   mod_counter_ctrl #(.WIDTH(3), .PASS_W(4)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .Stop    (Stop),
      .Hold    (Hold),
      .Down    (Down),
      .Modulus (Modulus),
      .Passes  (Passes),
      .Count   (Count),
      .Wrap    (Wrap),
      .Busy    (Busy),
      .Done    (Done),
      .Error   (Error)
   );

   always #5 Clock = ~Clock;

   // Behavioural model: a run is either active or not, and may be paused.
   int mCount, mMod, mPasses, mPassDone;
   bit mActive, mPaused, mDown, mWrap, mDone, mErr;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mCount = 0; mMod = 0; mPasses = 0; mPassDone = 0;
         mActive = 0; mPaused = 0; mDown = 0;
         mWrap = 0; mDone = 0; mErr = 0;
      end else begin
         mWrap = 0; mDone = 0; mErr = 0;
         if (!mActive) begin
            if (!Stop && Start) begin
               if (int'(Modulus) >= 2) begin
                  mMod = int'(Modulus); mDown = Down; mPasses = int'(Passes);
                  mPassDone = 0; mActive = 1; mPaused = 0;
                  mCount = Down ? mMod - 1 : 0;
               end else begin
                  mErr = 1;
               end
            end
         end else if (Stop) begin
            mActive = 0; mPaused = 0; mCount = 0;
         end else if (mPaused) begin
            if (!Hold) mPaused = 0;
         end else if (Hold) begin
            mPaused = 1;
         end else begin
            if (mDown) begin
               mWrap  = (mCount == 0);
               mCount = (mCount + mMod - 1) % mMod;
            end else begin
               mWrap  = (mCount == mMod - 1);
               mCount = (mCount + 1) % mMod;
            end
            if (mWrap && mPasses != 0) begin
               mPassDone++;
               if (mPassDone == mPasses) begin
                  mDone = 1; mActive = 0;
               end
            end
         end
      end
   end

   // Every cycle out of reset, the DUT must agree with the model.
   always @(negedge Clock) begin
      if (!Reset) begin
         vectors++;
         if (int'(Count) != mCount || Wrap != mWrap || Busy != mActive ||
             Done != mDone || Error != mErr) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t: got count=%0d wrap=%0b busy=%0b done=%0b err=%0b, want count=%0d wrap=%0b busy=%0b done=%0b err=%0b",
                     $time, Count, Wrap, Busy, Done, Error, mCount, mWrap, mActive, mDone, mErr);
         end
      end
   end

   task automatic applyStimulus(input bit st, input bit sp, input bit hd, input bit dn,
                                input int m, input int p);
      Start   = st;
      Stop    = sp;
      Hold    = hd;
      Down    = dn;
      Modulus = 3'(m);
      Passes  = 4'(p);
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic checkOutput(input string name, input int c, input bit w, input bit b,
                              input bit d, input bit e);
      vectors++;
      if (int'(Count) != c || Wrap != w || Busy != b || Done != d || Error != e) begin
         miscompares++;
         $display("[TB] FAIL %s: got count=%0d wrap=%0b busy=%0b done=%0b err=%0b, want count=%0d wrap=%0b busy=%0b done=%0b err=%0b",
                  name, Count, Wrap, Busy, Done, Error, c, w, b, d, e);
      end
   endtask

   int upSeq[9] = '{1, 2, 3, 4, 0, 1, 2, 3, 4};

   initial begin
      repeat (2) @(negedge Clock);
      checkOutput("reset_state", 0, 0, 0, 0, 0);
      Reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("idle_after_reset", 0, 0, 0, 0, 0);

      // Up count, M=5, two passes
      applyStimulus(1, 0, 0, 0, 5, 2);
      checkOutput("up_start", 0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 0, 0, 1, 7, 0);
         checkOutput("up_step", upSeq[i], (i == 4), 1, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("up_done", 0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("up_pulses_clear", 0, 0, 0, 0, 0);

      // Down count, M=3, single pass
      applyStimulus(1, 0, 0, 1, 3, 1);
      checkOutput("down_start", 2, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("down_1", 1, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("down_0", 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("down_done", 2, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("down_hold_value", 2, 0, 0, 0, 0);

      // Free-run with a hold window, then Stop
      applyStimulus(1, 0, 0, 0, 5, 0);
      checkOutput("hold_start", 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("hold_pre", 2, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("hold_a", 2, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("hold_b", 2, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("hold_release", 2, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("hold_resume", 3, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("free_wrap", 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("stop_run", 0, 0, 0, 0, 0);

      // Stop from PAUSE
      applyStimulus(1, 0, 0, 1, 6, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("pause_enter", 5, 0, 1, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("pause_stop", 0, 0, 0, 0, 0);

      // Rejected and suppressed starts
      applyStimulus(1, 0, 0, 0, 1, 3);
      checkOutput("err_m1", 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("err_clear", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("err_m0", 0, 0, 0, 0, 1);
      applyStimulus(1, 1, 0, 0, 5, 0);
      checkOutput("start_stop", 0, 0, 0, 0, 0);

      // Start while busy, inputs changed mid-run: latched M=5 must rule
      applyStimulus(1, 0, 0, 0, 5, 0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 0, 0, 1, 7, 1);
      checkOutput("ignore_at4", 4, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 1, 7, 1);
      checkOutput("ignore_wrap", 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pre_reset", 3, 0, 1, 0, 0);

      // Asynchronous reset mid-run
      #2 Reset = 1'b1;
      #1 checkOutput("async_reset", 0, 0, 0, 0, 0);
      @(negedge Clock);
      Reset = 1'b0;
      applyStimulus(1, 0, 0, 1, 4, 1);
      checkOutput("post_reset_start", 3, 0, 1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_reset_last", 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_reset_done", 3, 1, 0, 1, 0);

      // Largest modulus, up, one pass
      applyStimulus(1, 0, 0, 0, 7, 1);
      repeat (6) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("m7_top", 6, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("m7_done", 0, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
